muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit that sits directly downstream of the register file.
- Consumes read_data1/read_data2 as operand_a/operand_b together with the decoded funct3 and rd.
- Produces a 64-bit result plus destination register index for the writeback mux, which drives register_file write_data/rd/reg_write.
- Multi-cycle; the pipeline stalls on busy.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a rising edge where busy=0
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  input  XLEN  rs1 value (multiplicand/dividend)
- operand_b  input  XLEN  rs2 value (multiplier/divisor)
- rd_in  input  5  destination register of the request
- kill  input  1  synchronous abort (pipeline flush)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  result; held until the next accepted start
- rd_out  output  5  rd latched at accept

Behaviour:
- Reset: async on rst_n=0 regardless of state. State=IDLE; busy=0, done=0, result=0, rd_out=0; internal registers and counter cleared. Reset mid-operation discards the op; no done follows.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On edge with start=1, latch funct3, rd_in and operand magnitudes (abs value for signed operands per op); record result sign.
  - Set busy=1 and counter=0.
  - Normal case goes to CALC.
  - Special divide cases go directly to FIXUP:
    - divisor=0
    - signed overflow: DIV/REM with a=0x8000_0000_0000_0000, b=all-ones
- CALC:
  - One iteration per cycle; counter increments.
  - Multiply: shift-add on a 2*XLEN product.
  - Divide: restoring, one quotient bit per cycle.
  - After XLEN iterations (counter==XLEN-1 on that edge), go to FIXUP.
- FIXUP, one cycle:
  - Apply two's-complement sign correction.
  - Select the output: low half (MUL), high half (MULH*), quotient or remainder.
  - Write result and rd_out; go to DONE.
- Special results:
  - Divide by zero: DIV/DIVU = all-ones; REM/REMU = operand_a.
  - Overflow: DIV = 0x8000_0000_0000_0000; REM = 0.
- Signedness: MULHSU treats a as signed, b as unsigned. Remainder sign follows the dividend; quotient truncates toward zero.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start=1 in the DONE cycle is accepted (back-to-back): done pulse and new busy coexist; next cycle busy=1, done=0.
- Latency (accept edge E0):
  - Normal: CALC on E1..E64, FIXUP E65, done visible the cycle after E65 (65 cycles).
  - Special: FIXUP at E1, done visible after E1 (1 cycle).
- busy=1 from after E0 until the DONE cycle. start while busy is ignored; operands are not re-sampled.
- kill=1 on any edge in CALC or FIXUP: return to IDLE, busy=0, no done; result and rd_out keep their previous values.
  - kill in IDLE has no effect. kill and start on the same IDLE edge: kill wins, nothing accepted.
- No output is combinational from any input.

Decomposition:
- muldiv_pkg:
  - funct3 localparams (OP_MUL..OP_REMU)
  - state enum (IDLE, CALC, FIXUP, DONE)
  - XLEN default
  - constants MIN_SIGNED and ALL_ONES
- Sub-module muldiv_step: purely combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Output: next accumulator.
  - Keeps the FSM/counter top separate from the arithmetic.

Test Plan:
1. MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3) -> result 0xFFFF_FFFF_FFFF_FFEB and rd_out=rd_in, with done exactly 65 cycles after the accept edge; busy=1 throughout, and result unchanged before done.
2. MULHU a=all-ones, b=2 -> 0x1; MULH a=all-ones, b=all-ones -> 0x0; MULHSU a=all-ones, b=2 -> all-ones.
3. DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM a=-7, b=2 -> all-ones (-1); DIVU a=100, b=7 -> 14; REMU -> 2.
4. DIVU a=5, b=0 -> all-ones; REMU a=5, b=0 -> 5; DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM -> 0. Each has done 1 cycle after accept.
5. start pulsed with different operands at cycle 10 of an op -> ignored, first result correct; start asserted in the DONE cycle -> second op accepted, its done 65 cycles later.
6. kill at cycle 30 of CALC -> busy=0 next cycle, no done, result retains prior value; rst_n=0 at cycle 20 of another op -> busy=done=result=rd_out=0 immediately, no later done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 64;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// The accumulator is {high, low}:
//   multiply: high = partial product, low = remaining multiplier bits
//   divide:   high = partial remainder, low = dividend bits / quotient bits
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  step_mode_t            mode,
  input  logic [2*XLEN-1:0]     acc,
  input  logic [XLEN-1:0]       operand,
  output logic [2*XLEN-1:0]     acc_next
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shifted;
  logic [XLEN:0]   div_trial;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;

  // Compute both candidate iterations and pick one by mode
  always_comb begin
    // multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right, carry included
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};

    // divide: bring the next dividend bit into the remainder, try a subtract
    div_shifted = acc[2*XLEN-1:XLEN-1];
    div_trial   = div_shifted - {1'b0, operand};
    div_ge      = (div_shifted >= {1'b0, operand});
    div_rem     = div_ge ? div_trial[XLEN-1:0] : div_shifted[XLEN-1:0];

    if (mode == STEP_DIV) begin
      acc_next = {div_rem, acc[XLEN-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit. Operands are reduced to magnitudes
// at accept, XLEN iterations run in CALC, and FIXUP restores the sign and
// picks the requested half/quotient/remainder. Divide-by-zero and signed
// overflow skip CALC and take a precomputed result.
//
// Handshake: a request is accepted on a rising edge with start=1 while the
// unit is IDLE or DONE and kill=0; busy is high from the accept until the
// DONE cycle, and done is a single-cycle pulse with result/rd_out valid.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   operand_q;
  logic              neg_q;
  logic              spec_q;
  logic [XLEN-1:0]   spec_val_q;

  // Accept-time decode
  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   spec_val;

  // Iteration and fixup
  step_mode_t        step_mode;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot_fixed, rem_fixed, fixed_result;

  assign accept = start && !kill && (state == IDLE || state == DONE);

  // Operand magnitudes, result sign and special-case detection for the request
  always_comb begin
    a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];
    mag_a    = a_neg ? (~operand_a + 1'b1) : operand_a;
    mag_b    = b_neg ? (~operand_b + 1'b1) : operand_b;
    is_div   = funct3[2];
    div_zero = is_div && (operand_b == '0);
    div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
               (operand_a == MIN_SIGNED) && (operand_b == ALL_ONES);
    // funct3[1] separates remainder from quotient among the divides
    spec_val = '0;
    if (div_zero) begin
      spec_val = funct3[1] ? operand_a : ALL_ONES;
    end else if (div_ovf) begin
      spec_val = funct3[1] ? {XLEN{1'b0}} : MIN_SIGNED;
    end
  end

  assign step_mode = op_q[2] ? STEP_DIV : STEP_MUL;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (step_mode),
    .acc      (acc),
    .operand  (operand_q),
    .acc_next (acc_next)
  );

  // Sign correction and output selection for the FIXUP cycle
  always_comb begin
    prod_fixed = neg_q ? (~acc + 1'b1) : acc;
    quot_fixed = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fixed  = neg_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                         fixed_result = prod_fixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fixed_result = prod_fixed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fixed_result = quot_fixed;
      default:                        fixed_result = rem_fixed;
    endcase
    if (spec_q) begin
      fixed_result = spec_val_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = (div_zero || div_ovf) ? FIXUP : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          state_next = IDLE;
        end else if (count == LAST_ITER) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = kill ? IDLE : DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only
  always_comb begin
    busy = (state == CALC) || (state == FIXUP);
    done = (state == DONE);
  end

  // Datapath registers: latch at accept, iterate in CALC, publish in FIXUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      acc        <= '0;
      operand_q  <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      if (accept) begin
        count      <= '0;
        op_q       <= funct3;
        rd_q       <= rd_in;
        neg_q      <= (funct3 == OP_REM) ? a_neg : (a_neg ^ b_neg);
        spec_q     <= div_zero || div_ovf;
        spec_val_q <= spec_val;
        if (is_div) begin
          acc       <= {{XLEN{1'b0}}, mag_a};
          operand_q <= mag_b;
        end else begin
          acc       <= {{XLEN{1'b0}}, mag_b};
          operand_q <= mag_a;
        end
      end else if (state == CALC && !kill) begin
        acc   <= acc_next;
        count <= count + CW'(1);
      end else if (state == FIXUP && !kill) begin
        result <= fixed_result;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops
// against an arithmetic reference model, and hand-written sequences for
// ignored start, back-to-back accept, kill and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [4:0]   rd_in = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [4:0]   rd_out;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: straight from the M-extension rules, 128-bit arithmetic
  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb, sub;
    logic [2*W-1:0]        ua, ub, p;
    logic signed [W-1:0]   sa64, sb64, sq;
    sa   = {{W{a[W-1]}}, a};
    sb   = {{W{b[W-1]}}, b};
    ua   = {{W{1'b0}}, a};
    ub   = {{W{1'b0}}, b};
    sub  = ub;
    sa64 = a;
    sb64 = b;
    case (f)
      3'd0: begin p = ua * ub; return p[W-1:0]; end
      3'd1: begin p = sa * sb; return p[2*W-1:W]; end
      3'd2: begin p = sa * sub; return p[2*W-1:W]; end
      3'd3: begin p = ua * ub; return p[2*W-1:W]; end
      3'd4: begin
        if (b == '0) return ONES;
        if (a == MINV && b == ONES) return MINV;
        sq = sa64 / sb64;
        return sq;
      end
      3'd5: return (b == '0) ? ONES : a / b;
      3'd6: begin
        if (b == '0) return a;
        if (a == MINV && b == ONES) return '0;
        sq = sa64 % sb64;
        return sq;
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (f[2] && b == '0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == MINV && b == ONES) return 1;
    return 65;
  endfunction

  // ---------------- driver tasks ----------------
  // Called away from the clock edge; returns 1 time unit after the accept edge
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd);
    funct3    = f;
    operand_a = a;
    operand_b = b;
    rd_in     = rd;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    // scramble inputs: the unit must have latched them at accept
    operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
    rd_in     = 5'($urandom);
    funct3    = 3'($urandom);
  endtask

  // Counts edges until done is seen; busy must stay high and result frozen
  task automatic wait_done(input string name, output int lat);
    logic [W-1:0] held;
    int bad;
    held = result;
    bad  = 0;
    lat  = 0;
    if (!busy && !done) bad++;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (!busy || result !== held) bad++;
    end
    check({name, "_busy_hold"}, W'(bad), '0);
    if (!done) check({name, "_timeout"}, W'(done), W'(1));
    else       check({name, "_busy_in_done"}, W'(busy), '0);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check(name, W'(seen), '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
    string        name;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int lat;
    logic [2:0]   f;
    logic [W-1:0] a, b, e;
    logic [4:0]   rd;

    tbl[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7_m3"};
    tbl[1]  = '{3'd3, ONES, 64'd2, 64'd1, 65, "mulhu_ones_2"};
    tbl[2]  = '{3'd1, ONES, ONES, 64'd0, 65, "mulh_m1_m1"};
    tbl[3]  = '{3'd2, ONES, 64'd2, ONES, 65, "mulhsu_m1_2"};
    tbl[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2"};
    tbl[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem_m7_2"};
    tbl[6]  = '{3'd5, 64'd100, 64'd7, 64'd14, 65, "divu_100_7"};
    tbl[7]  = '{3'd7, 64'd100, 64'd7, 64'd2, 65, "remu_100_7"};
    tbl[8]  = '{3'd5, 64'd5, 64'd0, ONES, 1, "divu_by0"};
    tbl[9]  = '{3'd7, 64'd5, 64'd0, 64'd5, 1, "remu_by0"};
    tbl[10] = '{3'd4, MINV, ONES, MINV, 1, "div_ovf"};
    tbl[11] = '{3'd6, MINV, ONES, 64'd0, 1, "rem_ovf"};
    tbl[12] = '{3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7_m2"};
    tbl[13] = '{3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "rem_7_m2"};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_result", result, '0);
    check("rst_rd_out", W'(rd_out), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 14; i++) begin
      rd = 5'(i + 1);
      issue(tbl[i].f, tbl[i].a, tbl[i].b, rd);
      wait_done(tbl[i].name, lat);
      check({tbl[i].name, "_result"}, result, tbl[i].exp);
      check({tbl[i].name, "_rd"}, W'(rd_out), W'(rd));
      check({tbl[i].name, "_latency"}, W'(lat), W'(tbl[i].lat));
      @(posedge clk);
      #1;
      check({tbl[i].name, "_done_pulse"}, W'(done), '0);
    end

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MINV; b = ONES; end
        2: b = 64'($urandom_range(1, 20));
        3: a = 64'($urandom_range(0, 1000));
        4: b = -64'($urandom_range(1, 20));
        default: ;
      endcase
      rd = 5'($urandom);
      exp_q.push_back(ref_model(f, a, b));
      issue(f, a, b, rd);
      wait_done("rand", lat);
      check("rand_result", result, exp_q.pop_front());
      check("rand_latency", W'(lat), W'(ref_latency(f, a, b)));
      check("rand_rd", W'(rd_out), W'(rd));
    end

    // start while busy is ignored
    issue(3'd0, 64'd1234, 64'd5678, 5'd11);
    repeat (10) begin @(posedge clk); #1; end
    funct3 = 3'd5; operand_a = 64'd99; operand_b = 64'd3; rd_in = 5'd12; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start", lat);
    check("ignored_start_latency", W'(lat + 11), W'(65));
    check("ignored_start_result", result, 64'd7006652);
    check("ignored_start_rd", W'(rd_out), W'(5'd11));

    // back-to-back accept in the DONE cycle
    issue(3'd5, 64'd1000, 64'd10, 5'd4);
    wait_done("b2b_first", lat);
    check("b2b_first_result", result, 64'd100);
    check("b2b_first_done", W'(done), W'(1));
    issue(3'd0, 64'd6, 64'd7, 5'd5);
    check("b2b_busy_after", W'(busy), W'(1));
    check("b2b_done_after", W'(done), '0);
    wait_done("b2b_second", lat);
    check("b2b_second_latency", W'(lat), W'(65));
    check("b2b_second_result", result, 64'd42);
    check("b2b_second_rd", W'(rd_out), W'(5'd5));

    // kill mid-CALC
    issue(3'd5, 64'd100, 64'd7, 5'd9);
    wait_done("pre_kill", lat);
    check("pre_kill_result", result, 64'd14);
    issue(3'd0, 64'd3, 64'd3, 5'd3);
    repeat (29) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", W'(busy), '0);
    check("kill_done", W'(done), '0);
    check("kill_result_kept", result, 64'd14);
    check("kill_rd_kept", W'(rd_out), W'(5'd9));
    watch_no_done("kill_no_done", 80);

    // kill and start together in IDLE: nothing accepted
    funct3 = 3'd0; operand_a = 64'd2; operand_b = 64'd2; rd_in = 5'd1;
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle_busy", W'(busy), '0);
    watch_no_done("kill_start_idle_no_done", 70);

    // asynchronous reset mid-operation
    issue(3'd3, ONES, ONES, 5'd17);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst_busy", W'(busy), '0);
    check("arst_done", W'(done), '0);
    check("arst_result", result, '0);
    check("arst_rd_out", W'(rd_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("arst_no_done", 80);

    // recovery after reset
    issue(3'd7, 64'd17, 64'd5, 5'd30);
    wait_done("post_reset", lat);
    check("post_reset_result", result, 64'd2);
    check("post_reset_rd", W'(rd_out), W'(5'd30));

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
